// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, load funct3 encodings and the MEM->WB entry layout.
package core_pkg;

  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Fields are sized for the widest core; narrower cores use the low XLEN bits.
  typedef struct packed {
    logic [31:0]          instr;
    logic [MAX_XLEN-1:0]  pc;
    logic [MAX_XLEN-1:0]  alu;
    logic [MAX_XLEN-1:0]  ldata;
  } mem_wb_t;

  function automatic logic writes_rd(input logic [6:0] opcode);
    return !(opcode inside {OP_BRANCH, OP_STORE, OP_FENCE, OP_SYSTEM});
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/half/word/double from an aligned memory word.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  ldata,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  data,
  output logic             bad
);

  logic [XLEN-1:0] sh;
  assign sh = ldata >> {off, 3'b000};

  always_comb begin
    data = '0;
    bad  = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(sh[7:0]));
      F3_LBU: data = XLEN'(sh[7:0]);
      F3_LH: begin
        bad  = off[0];
        data = XLEN'($signed(sh[15:0]));
      end
      F3_LHU: begin
        bad  = off[0];
        data = XLEN'(sh[15:0]);
      end
      F3_LW: begin
        bad  = (off[1:0] != 2'b00);
        data = XLEN'($signed(sh[31:0]));
      end
      // Word-unsigned and doubleword only exist on a 64-bit core.
      F3_LWU: begin
        bad  = (XLEN == 32) || (off[1:0] != 2'b00);
        data = XLEN'(sh[31:0]);
      end
      F3_LD: begin
        bad  = (XLEN == 32) || (off != '0);
        data = sh;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: one-entry MEM->WB register, result select, RF write port and retire count.
module wb_stage_pipe
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int RET_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [31:0]          m_instr,
  input  logic [XLEN-1:0]      m_pc,
  input  logic [XLEN-1:0]      m_alu,
  input  logic [XLEN-1:0]      m_ldata,
  input  logic                 rf_stall,
  output logic                 wb_reg_en,
  output logic [REG_AW-1:0]    wb_reg_id,
  output logic [XLEN-1:0]      wb_reg_data,
  output logic                 wb_fault,
  output logic [RET_CNT_W-1:0] ret_cnt
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic    vld_p1;
  mem_wb_t ent_p1;
  logic    wb_fire;
  logic    accept;

  assign wb_fire = vld_p1 & ~rf_stall;
  assign m_ready = ~vld_p1 | wb_fire;
  assign accept  = m_valid & m_ready;

  // ---- stage p1: MEM->WB entry register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (wb_fire) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ent_p1 <= '{instr: m_instr,
                  pc:    MAX_XLEN'(m_pc),
                  alu:   MAX_XLEN'(m_alu),
                  ldata: MAX_XLEN'(m_ldata)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt <= '0;
    end else if (wb_fire) begin
      ret_cnt <= ret_cnt + RET_CNT_W'(1);
    end
  end

  // ---- stage p1 output: decode, load format, result select ----
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            is_load;
  logic            fault;
  logic [XLEN-1:0] alu_x;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ld_data;
  logic            ld_bad;
  logic [XLEN-1:0] result;
  logic            unused_ent;

  assign opcode   = ent_p1.instr[6:0];
  assign rd       = ent_p1.instr[11:7];
  assign is_load  = (opcode == OP_LOAD);
  assign alu_x    = ent_p1.alu[XLEN-1:0];
  assign pc_plus4 = ent_p1.pc[XLEN-1:0] + XLEN'(4);
  assign unused_ent = ^ent_p1;

  load_align #(.XLEN(XLEN)) u_load_align (
    .ldata  (ent_p1.ldata[XLEN-1:0]),
    .off    (alu_x[OFF_W-1:0]),
    .funct3 (ent_p1.instr[14:12]),
    .data   (ld_data),
    .bad    (ld_bad)
  );

  always_comb begin
    result = alu_x;
    if (is_load) begin
      result = ld_data;
    end else if (opcode == OP_JAL || opcode == OP_JALR) begin
      result = pc_plus4;
    end
  end

  assign fault       = is_load & ld_bad;
  assign wb_reg_en   = wb_fire & writes_rd(opcode) & (rd != 5'd0) & ~fault;
  assign wb_fault    = wb_fire & fault;
  assign wb_reg_id   = vld_p1 ? REG_AW'(rd) : '0;
  assign wb_reg_data = vld_p1 ? result : '0;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed scoreboard bench for wb_stage_pipe, plus a narrow-counter instance for wrap checking.
module tb_wb_stage_pipe;
  import core_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_instr, m_pc, m_alu, m_ldata;
  logic        rf_stall;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_id;
  logic [31:0] wb_reg_data;
  logic        wb_fault;
  logic [31:0] ret_cnt;

  logic        m_ready_w, wb_reg_en_w, wb_fault_w;
  logic [4:0]  wb_reg_id_w;
  logic [31:0] wb_reg_data_w;
  logic [2:0]  ret_cnt_w;

  wb_stage_pipe #(.XLEN(32), .REG_AW(5), .RET_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
    .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_ldata(m_ldata),
    .rf_stall(rf_stall), .wb_reg_en(wb_reg_en), .wb_reg_id(wb_reg_id),
    .wb_reg_data(wb_reg_data), .wb_fault(wb_fault), .ret_cnt(ret_cnt)
  );

  wb_stage_pipe #(.XLEN(32), .REG_AW(5), .RET_CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready_w),
    .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_ldata(m_ldata),
    .rf_stall(rf_stall), .wb_reg_en(wb_reg_en_w), .wb_reg_id(wb_reg_id_w),
    .wb_reg_data(wb_reg_data_w), .wb_fault(wb_fault_w), .ret_cnt(ret_cnt_w)
  );

  typedef struct {
    logic        en;
    logic [4:0]  id;
    logic [31:0] data;
    logic        chk_data;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_cnt;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, pc, alu, ld);
    exp_t e;
    logic [6:0]  op;
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    op  = ins[6:0];
    off = alu[1:0];
    b   = ld[8*off +: 8];
    h   = (off[1]) ? ld[31:16] : ld[15:0];
    e.id = ins[11:7];
    e.fault = 1'b0;
    e.data = alu;
    if (op == 7'b0000011) begin
      case (ins[14:12])
        3'b000: e.data = {{24{b[7]}}, b};
        3'b100: e.data = {24'd0, b};
        3'b001: begin e.fault = off[0]; e.data = {{16{h[15]}}, h}; end
        3'b101: begin e.fault = off[0]; e.data = {16'd0, h}; end
        3'b010: begin e.fault = (off != 2'd0); e.data = ld; end
        default: e.fault = 1'b1;
      endcase
    end else if (op == 7'b1101111 || op == 7'b1100111) begin
      e.data = pc + 32'd4;
    end
    e.chk_data = !e.fault;
    e.en = !(op == 7'b1100011 || op == 7'b0100011 || op == 7'b0001111 || op == 7'b1110011)
           && (e.id != 5'd0) && !e.fault;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic stall);
    exp_t e;
    logic has;
    has = (exp_q.size() != 0);
    if (has) e = exp_q[0];
    else     e = '{en: 1'b0, id: 5'd0, data: 32'd0, chk_data: 1'b1, fault: 1'b0};
    chk("m_ready", m_ready, !has || !stall);
    chk("ret_cnt", ret_cnt, exp_cnt);
    chk("ret_cnt_w", ret_cnt_w, exp_cnt[2:0]);
    chk("wb_reg_en", wb_reg_en, e.en && !stall);
    chk("wb_fault", wb_fault, e.fault && !stall);
    chk("wb_reg_id", wb_reg_id, e.id);
    if (e.chk_data) chk("wb_reg_data", wb_reg_data, e.data);
  endtask

  // One clock: check current outputs, retire/accept in the model, drive the next inputs.
  task automatic cycle(input logic v, input logic [31:0] ins, pc, alu, ld,
                       input logic stall, output logic acc);
    logic fire;
    @(negedge clk);
    rf_stall = stall;
    #1;
    check_outputs(stall);
    fire = (exp_q.size() != 0) && !stall;
    acc  = v && ((exp_q.size() == 0) || !stall);
    m_valid = v; m_instr = ins; m_pc = pc; m_alu = alu; m_ldata = ld;
    if (fire) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (acc) exp_q.push_back(model(ins, pc, alu, ld));
  endtask

  task automatic idle(input logic stall);
    logic acc;
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, stall, acc);
  endtask

  task automatic send(input logic [31:0] ins, pc, alu, ld);
    logic acc;
    cycle(1'b1, ins, pc, alu, ld, 1'b0, acc);
    chk("send_accept", acc, 1'b1);
    idle(1'b0);
  endtask

  logic [31:0] s_ins[4], s_alu[4];
  logic [31:0] cnt0;
  logic        acc;
  int          idx;

  initial begin
    rst = 1'b1; m_valid = 1'b0; rf_stall = 1'b0;
    m_instr = '0; m_pc = '0; m_alu = '0; m_ldata = '0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b0);
    idle(1'b1);

    // ALU, loads, faults and non-writing ops, each followed by a retire cycle.
    send(enc(7'b0010011, 5'd5, 3'b000), 32'h0, 32'h1234, 32'h0);
    idle(1'b0);
    chk("addi_cnt", ret_cnt, 32'd1);
    send(enc(OP_LOAD, 5'd3, 3'b000), 32'h10, 32'h2002, 32'h0080_0000);
    send(enc(OP_LOAD, 5'd3, 3'b100), 32'h14, 32'h2002, 32'h0080_0000);
    send(enc(OP_LOAD, 5'd4, 3'b001), 32'h18, 32'h2002, 32'h8001_0000);
    send(enc(OP_LOAD, 5'd6, 3'b010), 32'h1c, 32'h2002, 32'hdead_beef);
    send(enc(OP_LOAD, 5'd6, 3'b011), 32'h20, 32'h2000, 32'hdead_beef);
    send(enc(OP_STORE, 5'd7, 3'b010), 32'h24, 32'h3000, 32'h0);
    send(enc(OP_BRANCH, 5'd8, 3'b000), 32'h28, 32'h1, 32'h0);
    send(enc(7'b0010011, 5'd0, 3'b000), 32'h2c, 32'h55, 32'h0);
    send(enc(OP_JAL, 5'd1, 3'b000), 32'h100, 32'h0, 32'h0);
    send(enc(OP_JALR, 5'd2, 3'b000), 32'hFFFF_FFFC, 32'h0, 32'h0);
    idle(1'b0);
    chk("wrap_cnt_w", ret_cnt_w, 3'd3);

    // Back-to-back stream with a three-cycle register-file stall in the middle.
    s_ins[0] = enc(7'b0010011, 5'd6, 3'b000); s_alu[0] = 32'h11;
    s_ins[1] = enc(OP_LOAD, 5'd7, 3'b100);    s_alu[1] = 32'h4001;
    s_ins[2] = enc(OP_JAL, 5'd8, 3'b000);     s_alu[2] = 32'h0;
    s_ins[3] = enc(7'b0110011, 5'd9, 3'b000); s_alu[3] = 32'h99;
    cnt0 = exp_cnt;
    idx = 0;
    for (int k = 0; k < 20 && (idx < 4 || exp_q.size() != 0); k++) begin
      if (idx < 4)
        cycle(1'b1, s_ins[idx], 32'h200 + 32'(idx * 4), s_alu[idx], 32'h0000_a500,
              (k >= 2 && k < 5), acc);
      else
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, (k >= 2 && k < 5), acc);
      if (acc) idx++;
    end
    idle(1'b0);
    chk("stream_done", (idx == 4) && (exp_q.size() == 0), 1'b1);
    chk("stream_cnt", ret_cnt, cnt0 + 32'd4);

    // Reset while an entry is held under stall.
    cycle(1'b1, enc(7'b0010011, 5'd10, 3'b000), 32'h0, 32'h77, 32'h0, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    rst = 1'b1; rf_stall = 1'b1; m_valid = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b1);
    idle(1'b0);
    chk("rst_cnt", ret_cnt, 32'd0);
    send(enc(7'b0010011, 5'd11, 3'b000), 32'h0, 32'h5, 32'h0);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
